// File: rtl/axi_pkg.sv
// Shared AXI encodings and address-sequencing helpers for the read generator,
// read responder and future write responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_32B    = 3'd5;

  typedef enum logic {
    ST_IDLE,
    ST_DATA
  } rd_state_e;

  // Callers truncate the 64-bit result to their own address width, which
  // gives the modulo-2^AW wrap for INCR.
  function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                input logic [2:0]  size,
                                                input logic [7:0]  len,
                                                input logic [1:0]  burst);
    logic [63:0] bytes;
    logic [63:0] wsz;
    logic [63:0] nxt;
    bytes = 64'd1 << size;
    wsz   = ({56'd0, len} + 64'd1) * bytes;
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = (addr & ~(wsz - 64'd1)) | ((addr + bytes) & (wsz - 64'd1));
      default:     nxt = addr + bytes;
    endcase
    return nxt;
  endfunction

  function automatic logic axi_burst_err(input logic [2:0] size,
                                         input logic [7:0] len,
                                         input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) &&
               !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    return (burst == 2'b11) || (size > SIZE_32B) || bad_wrap;
  endfunction

endpackage

// File: rtl/axi_rd_mem.sv
// Word memory with one sideband write port and a registered read port that
// holds its output unless re_i is asserted; rzero_i loads zero instead of data.
module axi_rd_mem #(
  parameter int DEPTH = 16,
  parameter int DW    = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     re_i,
  input  logic                     rzero_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read samples the pre-write value when both ports hit the same word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_read_slave.sv
// AXI4 read responder: one outstanding burst, beats streamed from axi_rd_mem.
//   state   | meaning
//   ST_IDLE | arready high (from one cycle after reset), waiting for AR
//   ST_DATA | burst active, rvalid high until the rlast handshake
module axi_read_slave
  import axi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 32,
  parameter int IDW   = 7,
  parameter int DW    = 256
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [IDW-1:0]           arid,
  input  logic [AW-1:0]            araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [IDW-1:0]           rid,
  output logic [DW-1:0]            rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic                     mem_we,
  input  logic [$clog2(DEPTH)-1:0] mem_waddr,
  input  logic [DW-1:0]            mem_wdata
);

  localparam int IW = $clog2(DEPTH);

  rd_state_e      state_q;
  logic           arready_q;
  logic           rvalid_q;
  logic           rlast_q;
  logic [1:0]     rresp_q;
  logic [IDW-1:0] rid_q;
  logic [AW-1:0]  addr_q;
  logic [7:0]     len_q;
  logic [2:0]     size_q;
  logic [1:0]     burst_q;
  logic [7:0]     cnt_q;
  logic           berr_q;

  logic           ar_hs;
  logic           r_hs;
  logic [AW-1:0]  next_addr;
  logic [AW-1:0]  beat_addr;
  logic           beat_berr;
  logic           beat_err;
  logic           rd_en;

  assign ar_hs = arvalid && arready_q;
  assign r_hs  = rvalid_q && rready;

  // beat_addr is the address of the beat being loaded on this edge: the AR
  // address on acceptance, the successor of the current beat otherwise.
  always_comb begin
    next_addr = AW'(axi_next_addr(64'(addr_q), size_q, len_q, burst_q));
    if (state_q == ST_IDLE) begin
      beat_addr = araddr;
      beat_berr = axi_burst_err(arsize, arlen, arburst);
    end else begin
      beat_addr = next_addr;
      beat_berr = berr_q;
    end
    beat_err = beat_berr || ((beat_addr >> (5 + IW)) != '0);
    rd_en    = ar_hs || (r_hs && !rlast_q);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      berr_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            state_q   <= ST_DATA;
            arready_q <= 1'b0;
            rid_q     <= arid;
            addr_q    <= araddr;
            len_q     <= arlen;
            size_q    <= arsize;
            burst_q   <= arburst;
            berr_q    <= beat_berr;
            cnt_q     <= '0;
            rvalid_q  <= 1'b1;
            rlast_q   <= (arlen == 8'd0);
            rresp_q   <= beat_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              state_q   <= ST_IDLE;
              arready_q <= 1'b1;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
            end else begin
              addr_q  <= next_addr;
              cnt_q   <= cnt_q + 8'd1;
              rlast_q <= (cnt_q + 8'd1 == len_q);
              rresp_q <= beat_err ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  axi_rd_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_mem (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (rd_en),
    .rzero_i (beat_err),
    .raddr_i (beat_addr[5 +: IW]),
    .rdata_o (rdata)
  );

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rresp   = rresp_q;
  assign rid     = rid_q;

endmodule

// File: tb/tb_axi_read_slave.sv
// Self-checking bench for axi_read_slave against a queue-based burst model.
module tb_axi_read_slave;

  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int IDW   = 7;
  localparam int DW    = 256;
  localparam int IW    = 4;

  logic           i_clk = 1'b0;
  logic           i_reset_n = 1'b0;
  logic [IDW-1:0] arid = '0;
  logic [AW-1:0]  araddr = '0;
  logic [7:0]     arlen = '0;
  logic [2:0]     arsize = '0;
  logic [1:0]     arburst = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready = 1'b0;
  logic           mem_we = 1'b0;
  logic [IW-1:0]  mem_waddr = '0;
  logic [DW-1:0]  mem_wdata = '0;

  always #5 i_clk = ~i_clk;

  axi_read_slave #(.DEPTH(DEPTH), .AW(AW), .IDW(IDW), .DW(DW)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arvalid   (arvalid),
    .arready   (arready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0]  mem_m [DEPTH];
  logic [DW-1:0]  exp_data[$];
  logic [1:0]     exp_resp[$];
  logic           exp_last[$];
  logic [DW-1:0]  got_data[$];
  logic [1:0]     got_resp[$];
  logic           got_last[$];
  logic [IDW-1:0] got_id[$];
  int lat_ok, stab_err, tmo, ar_ok;

  task automatic mem_write(input int idx, input logic [DW-1:0] d);
    mem_we    = 1'b1;
    mem_waddr = IW'(idx);
    mem_wdata = d;
    @(negedge i_clk);
    mem_we    = 1'b0;
    mem_m[idx] = d;
  endtask

  // Expected beats straight from the burst rules, using division/modulo
  // arithmetic on plain integers.
  task automatic build_expected(input longint addr, input int len, input int size, input int burst);
    longint a, bytes, wsz;
    bit bad;
    exp_data.delete(); exp_resp.delete(); exp_last.delete();
    a     = addr;
    bytes = longint'(1) << size;
    bad   = (burst == 3) || (size > 5) ||
            (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    for (int i = 0; i <= len; i++) begin
      if (bad || (a / 32) >= DEPTH) begin
        exp_data.push_back('0); exp_resp.push_back(2'b10);
      end else begin
        exp_data.push_back(mem_m[int'(a / 32)]); exp_resp.push_back(2'b00);
      end
      exp_last.push_back(i == len);
      if (burst == 2) begin
        wsz = (len + 1) * bytes;
        a   = (a / wsz) * wsz + ((a + bytes) % wsz);
      end else if (burst != 0) begin
        a = (a + bytes) % 64'h1_0000_0000;
      end
    end
  endtask

  // Drives one AR and collects R beats; stall_mode 0 = always ready,
  // 1 = fixed 1,0,0,1,0,1 pattern, 2 = random ready.
  task automatic do_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                          input int size, input int burst, input int stall_mode);
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [DW-1:0] h_d; logic [1:0] h_r; logic h_l; logic [IDW-1:0] h_id;
    bit held, done;
    int cyc, k;
    got_data.delete(); got_resp.delete(); got_last.delete(); got_id.delete();
    lat_ok = 0; stab_err = 0; tmo = 0; ar_ok = 0;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1; rready = 1'b0;
    cyc = 0;
    while (!arready && cyc < 50) begin @(negedge i_clk); cyc++; end
    if (!arready) begin tmo = 1; arvalid = 1'b0; return; end
    @(negedge i_clk);
    arvalid = 1'b0;
    lat_ok = int'(rvalid);
    held = 0; done = 0; cyc = 0; k = 0;
    h_d = '0; h_r = '0; h_l = 1'b0; h_id = '0;
    while (!done && cyc < 400) begin
      if (held && (!rvalid || rdata !== h_d || rresp !== h_r || rlast !== h_l || rid !== h_id))
        stab_err++;
      case (stall_mode)
        0:       rready = 1'b1;
        1:       rready = pat[k % 6];
        default: rready = 1'($urandom_range(0, 1));
      endcase
      k++;
      held = rvalid && !rready;
      h_d = rdata; h_r = rresp; h_l = rlast; h_id = rid;
      if (rvalid && rready) begin
        got_data.push_back(rdata); got_resp.push_back(rresp);
        got_last.push_back(rlast); got_id.push_back(rid);
        if (rlast || got_data.size() > len + 1) done = 1;
      end
      @(negedge i_clk);
      cyc++;
    end
    rready = 1'b0;
    if (!done) tmo = 1;
    ar_ok = int'(arready && !rvalid);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    n_tests++;
    if ({arready, rvalid, rlast} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got arready/rvalid/rlast=%b exp 000", {arready, rvalid, rlast});
    end
    n_tests++;
    if (rresp !== 2'b00 || rid !== '0 || rdata !== '0) begin
      n_fail++; $display("FAIL reset_data: got rresp=%b rid=%h rdata=%h exp all zero", rresp, rid, rdata);
    end
    i_reset_n = 1'b1;
    #1;
    n_tests++;
    if (arready !== 1'b0) begin n_fail++; $display("FAIL reset_release_arready: got %b exp 0", arready); end
    @(negedge i_clk);
    n_tests++;
    if (arready !== 1'b1) begin n_fail++; $display("FAIL idle_arready: got %b exp 1", arready); end
  endtask

  task automatic test_single();
    mem_write(0, {128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'hDEADBEEF_CAFEBABE_12345678_ABCDEF01});
    do_burst(7'h11, 32'h0, 0, 5, 1, 0);
    n_tests++;
    if (tmo != 0 || lat_ok != 1 || got_data.size() != 1) begin
      n_fail++; $display("FAIL single_handshake: got tmo=%0d lat=%0d beats=%0d exp 0 1 1", tmo, lat_ok, got_data.size());
    end else begin
      n_tests++;
      if (got_data[0][127:0] !== 128'hDEADBEEF_CAFEBABE_12345678_ABCDEF01 || got_last[0] !== 1'b1 || got_resp[0] !== 2'b00) begin
        n_fail++; $display("FAIL single_beat: got data=%h last=%b resp=%b", got_data[0][127:0], got_last[0], got_resp[0]);
      end
    end
    n_tests++;
    if (ar_ok != 1) begin n_fail++; $display("FAIL single_arready_after: got %0d exp 1", ar_ok); end
  endtask

  task automatic test_incr_stall();
    for (int i = 1; i <= 4; i++) mem_write(i, DW'(i));
    for (int mode = 0; mode < 3; mode++) begin
      build_expected(32'h20, 3, 5, 1);
      do_burst(7'h15, 32'h20, 3, 5, 1, mode);
      n_tests++;
      if (tmo != 0 || lat_ok != 1 || got_data.size() != 4 || stab_err != 0) begin
        n_fail++;
        $display("FAIL incr_mode%0d_flow: got tmo=%0d lat=%0d beats=%0d stab_err=%0d exp 0 1 4 0",
                 mode, tmo, lat_ok, got_data.size(), stab_err);
      end else begin
        foreach (exp_data[i]) begin
          n_tests++;
          if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_resp[i] !== exp_resp[i] || got_id[i] !== 7'h15) begin
            n_fail++;
            $display("FAIL incr_mode%0d_beat%0d: got data=%0h last=%b resp=%b id=%h exp data=%0h last=%b resp=%b id=15",
                     mode, i, got_data[i], got_last[i], got_resp[i], got_id[i], exp_data[i], exp_last[i], exp_resp[i]);
          end
        end
      end
    end
  endtask

  // Scenario table: wrap, fixed and the three error classes.
  task automatic test_wrap_fixed_err();
    longint t_addr [5] = '{64'h60, 64'h40, 64'h200, 64'h0, 64'h0};
    int     t_len  [5] = '{3, 2, 1, 0, 2};
    int     t_bst  [5] = '{2, 0, 1, 3, 2};
    for (int n = 0; n < DEPTH; n++) mem_write(n, DW'(n));
    for (int t = 0; t < 5; t++) begin
      build_expected(t_addr[t], t_len[t], 5, t_bst[t]);
      do_burst(7'(t + 3), AW'(t_addr[t]), t_len[t], 5, t_bst[t], 0);
      n_tests++;
      if (tmo != 0 || got_data.size() != exp_data.size()) begin
        n_fail++; $display("FAIL scen%0d_count: got tmo=%0d beats=%0d exp 0 %0d", t, tmo, got_data.size(), exp_data.size());
      end else begin
        foreach (exp_data[i]) begin
          n_tests++;
          if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_resp[i] !== exp_resp[i]) begin
            n_fail++;
            $display("FAIL scen%0d_beat%0d: got data=%0h last=%b resp=%b exp data=%0h last=%b resp=%b",
                     t, i, got_data[i], got_last[i], got_resp[i], exp_data[i], exp_last[i], exp_resp[i]);
          end
        end
      end
    end
  endtask

  task automatic test_write_collision();
    logic [DW-1:0] a_d, b_d, c_d, d_d;
    a_d = {8{$urandom()}}; b_d = {8{$urandom()}}; c_d = {8{$urandom()}}; d_d = {8{$urandom()}};
    mem_write(1, a_d);
    mem_write(2, b_d);
    arid = 7'h2A; araddr = 32'h20; arlen = 8'd1; arsize = 3'd5; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
    @(negedge i_clk);
    arvalid = 1'b0;
    mem_we = 1'b1; mem_waddr = 4'd1; mem_wdata = c_d;
    @(negedge i_clk);
    mem_we = 1'b0;
    n_tests++;
    if (rvalid !== 1'b1 || rdata !== a_d) begin
      n_fail++; $display("FAIL stall_write_hold: got rvalid=%b rdata=%h exp 1 %h", rvalid, rdata, a_d);
    end
    rready = 1'b1;
    mem_we = 1'b1; mem_waddr = 4'd2; mem_wdata = d_d;
    @(negedge i_clk);
    rready = 1'b0; mem_we = 1'b0;
    n_tests++;
    if (rdata !== b_d || rlast !== 1'b1) begin
      n_fail++; $display("FAIL same_edge_old_data: got rdata=%h rlast=%b exp %h 1", rdata, rlast, b_d);
    end
    rready = 1'b1;
    @(negedge i_clk);
    rready = 1'b0;
    n_tests++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      n_fail++; $display("FAIL collision_end: got rvalid=%b arready=%b exp 0 1", rvalid, arready);
    end
    mem_m[1] = c_d;
    mem_m[2] = d_d;
  endtask

  task automatic test_random();
    int len, size, burst, b, errs;
    logic [AW-1:0] addr;
    errs = 0;
    for (int it = 0; it < 30; it++) begin
      repeat (2) mem_write(int'($urandom_range(0, DEPTH - 1)), {8{$urandom()}});
      size = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : 5;
      b = int'($urandom_range(0, 9));
      burst = (b < 2) ? 0 : (b < 6) ? 1 : (b < 9) ? 2 : 3;
      if (burst == 2 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      else len = int'($urandom_range(0, 15));
      addr = ($urandom_range(0, 7) == 0) ? AW'($urandom()) : AW'($urandom_range(0, DEPTH * 32 + 95));
      build_expected(longint'(addr), len, size, burst);
      do_burst(7'($urandom()), addr, len, size, burst, 2);
      n_tests++;
      if (tmo != 0 || lat_ok != 1 || stab_err != 0 || ar_ok != 1 || got_data.size() != exp_data.size()) begin
        n_fail++;
        $display("FAIL rand%0d_flow: got tmo=%0d lat=%0d stab=%0d ar_ok=%0d beats=%0d exp 0 1 0 1 %0d",
                 it, tmo, lat_ok, stab_err, ar_ok, got_data.size(), exp_data.size());
      end else begin
        foreach (exp_data[i])
          if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_resp[i] !== exp_resp[i] || got_id[i] !== arid) begin
            errs++;
            $display("FAIL rand%0d_beat%0d: addr=%h len=%0d size=%0d burst=%0d got data=%0h last=%b resp=%b exp data=%0h last=%b resp=%b",
                     it, i, addr, len, size, burst, got_data[i], got_last[i], got_resp[i], exp_data[i], exp_last[i], exp_resp[i]);
          end
      end
    end
    n_tests++;
    if (errs != 0) begin n_fail++; $display("FAIL rand_beats: got %0d bad beats exp 0", errs); end
  endtask

  task automatic test_reset_mid();
    arid = 7'h33; araddr = 32'h0; arlen = 8'd7; arsize = 3'd5; arburst = 2'b01; arvalid = 1'b1; rready = 1'b0;
    @(negedge i_clk);
    arvalid = 1'b0;
    rready = 1'b1;
    @(negedge i_clk);
    rready = 1'b0;
    n_tests++;
    if (rvalid !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: got rvalid=%b exp 1", rvalid); end
    i_reset_n = 1'b0;
    #1;
    n_tests++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || rlast !== 1'b0 || rdata !== '0) begin
      n_fail++; $display("FAIL midreset_immediate: got rvalid=%b arready=%b rlast=%b exp 0 0 0", rvalid, arready, rlast);
    end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    n_tests++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_release: got arready=%b rvalid=%b exp 1 0", arready, rvalid);
    end
    build_expected(64'h40, 0, 5, 1);
    do_burst(7'h01, 32'h40, 0, 5, 1, 0);
    n_tests++;
    if (tmo != 0 || got_data.size() != 1 || ar_ok != 1) begin
      n_fail++; $display("FAIL midreset_next_flow: got tmo=%0d beats=%0d ar_ok=%0d exp 0 1 1", tmo, got_data.size(), ar_ok);
    end else begin
      n_tests++;
      if (got_data[0] !== exp_data[0] || got_last[0] !== 1'b1 || got_resp[0] !== 2'b00 || got_id[0] !== 7'h01) begin
        n_fail++; $display("FAIL midreset_next_beat: got data=%0h last=%b resp=%b exp data=%0h 1 00", got_data[0], got_last[0], got_resp[0], exp_data[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_stall();
    test_wrap_fixed_err();
    test_write_collision();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
